// File: rtl/lane_pkg.sv
// Shared constants and types for the lane deserializer.
// Lane count limit, lane index width and FSM state encoding.
package lane_pkg;

   localparam int MAX_PORTS = 8;
   localparam int IDX_W     = $clog2(MAX_PORTS);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/lane_deserializer.sv
// Stream-to-lanes deserializer: packs PORT_NUM consecutive words into
// lanes a..h and presents them as one group over a valid/ready handshake.
module lane_deserializer
   import lane_pkg::*;
#(
   parameter int PORT_NUM = 2,
   parameter int WIDTH    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic             all_ones
);

   generate
      if (PORT_NUM < 1 || PORT_NUM > MAX_PORTS) begin : g_bad_ports
         $fatal(1, "lane_deserializer: PORT_NUM must be 1..8");
      end
   endgenerate

   localparam logic [IDX_W-1:0] LAST = IDX_W'(PORT_NUM - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic                 r_out_valid;
   logic                 r_all_ones;
   logic                 w_accept;
   logic                 w_wr_en;
   logic [IDX_W-1:0]     w_wr_idx;
   logic [WIDTH-1:0]     w_lane [MAX_PORTS];
   logic [MAX_PORTS-1:0] w_lane_ones;

   assign in_ready = rst_n &&
                     ((r_state == FILL) || ((r_state == HOLD) && out_ready));
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_idx;
      unique case (r_state)
         FILL: begin
            if (w_accept) begin
               w_wr_en = 1'b1;
               if (r_idx == LAST) begin
                  w_state_nxt = HOLD;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready && w_accept) begin
               // pass-through: the new group starts in lane a this cycle
               w_wr_en  = 1'b1;
               w_wr_idx = '0;
               if (PORT_NUM == 1) begin
                  w_state_nxt = HOLD;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = FILL;
                  w_idx_nxt   = IDX_W'(1);
               end
            end else if (out_ready) begin
               w_state_nxt = FILL;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
         end
      endcase
      if (flush) begin
         w_state_nxt = FILL;
         w_idx_nxt   = '0;
         w_wr_en     = 1'b0;
      end
   end

   generate
      for (genvar i = 0; i < MAX_PORTS; i++) begin : g_lane
         if (i < PORT_NUM) begin : g_used
            logic [WIDTH-1:0] r_lane;
            logic             w_hit;
            assign w_hit = w_wr_en && (w_wr_idx == IDX_W'(i));
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  r_lane <= '0;
               end else if (w_hit) begin
                  r_lane <= in_data;
               end
            end
            assign w_lane[i]      = r_lane;
            // all-ones of the lane value as it will be after this edge
            assign w_lane_ones[i] = w_hit ? (&in_data) : (&r_lane);
         end else begin : g_tie
            assign w_lane[i]      = '0;
            assign w_lane_ones[i] = 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_all_ones  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_out_valid <= (w_state_nxt == HOLD);
         r_all_ones  <= (w_state_nxt == HOLD) && (&w_lane_ones);
      end
   end

   assign out_valid = r_out_valid;
   assign all_ones  = r_all_ones;
   assign a = w_lane[0];
   assign b = w_lane[1];
   assign c = w_lane[2];
   assign d = w_lane[3];
   assign e = w_lane[4];
   assign f = w_lane[5];
   assign g = w_lane[6];
   assign h = w_lane[7];

endmodule

// File: tb/tb_lane_deserializer.sv
// Self-checking bench for lane_deserializer: four instances with
// PORT_NUM = 2, 8, 4, 3 exercised by scenario tasks and a group scoreboard.
module tb_lane_deserializer;

   localparam int ND = 4;

   logic       clk = 1'b0;
   logic       rst_n     [ND];
   logic       flush     [ND];
   logic       in_valid  [ND];
   logic       in_ready  [ND];
   logic [7:0] in_data   [ND];
   logic       out_valid [ND];
   logic       out_ready [ND];
   logic       all_ones  [ND];
   logic [7:0] ln        [ND][8];

   int pn [ND] = '{2, 8, 4, 3};

   typedef struct packed {
      logic [63:0] lanes;
      logic        ones;
   } exp_t;

   exp_t        sb [$];
   logic [63:0] m_acc  [ND];
   int          m_cnt  [ND];
   logic        m_ones [ND];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < ND; k++) begin : g_dut
      localparam int P = (k == 0) ? 2 : (k == 1) ? 8 : (k == 2) ? 4 : 3;
      lane_deserializer #(.PORT_NUM(P), .WIDTH(8)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n[k]),
         .flush    (flush[k]),
         .in_valid (in_valid[k]),
         .in_ready (in_ready[k]),
         .in_data  (in_data[k]),
         .out_valid(out_valid[k]),
         .out_ready(out_ready[k]),
         .a        (ln[k][0]),
         .b        (ln[k][1]),
         .c        (ln[k][2]),
         .d        (ln[k][3]),
         .e        (ln[k][4]),
         .f        (ln[k][5]),
         .g        (ln[k][6]),
         .h        (ln[k][7]),
         .all_ones (all_ones[k])
      );
   end

   function automatic logic [63:0] lanes_of(int dd);
      logic [63:0] v;
      for (int j = 0; j < 8; j++) v[8*j +: 8] = ln[dd][j];
      return v;
   endfunction

   function automatic void model_reset(int dd);
      m_acc[dd]  = '0;
      m_cnt[dd]  = 0;
      m_ones[dd] = 1'b1;
   endfunction

   // Expected group is built from the words the bench saw accepted
   function automatic void model_word(int dd, logic [7:0] w);
      exp_t t;
      m_acc[dd][8*m_cnt[dd] +: 8] = w;
      m_ones[dd] = m_ones[dd] && (w == 8'hFF);
      m_cnt[dd]++;
      if (m_cnt[dd] == pn[dd]) begin
         t.lanes = m_acc[dd];
         t.ones  = m_ones[dd];
         sb.push_back(t);
         model_reset(dd);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int dd, logic [7:0] w);
      int n = 0;
      in_valid[dd] = 1'b1;
      in_data[dd]  = w;
      @(negedge clk);
      while (!in_ready[dd] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[dd]) begin
         total_cnt++;
         $display("FAIL send_timeout dut%0d word=%h in_ready=%b exp=1",
                  dd, w, in_ready[dd]);
      end else begin
         model_word(dd, w);
      end
      tick();
      in_valid[dd] = 1'b0;
   endtask

   task automatic test_reset();
      for (int dd = 0; dd < ND; dd++) begin
         rst_n[dd]     = 1'b0;
         flush[dd]     = 1'b0;
         in_valid[dd]  = 1'b1;
         in_data[dd]   = 8'h5A;
         out_ready[dd] = 1'b0;
         model_reset(dd);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int dd = 0; dd < ND; dd++) begin
         total_cnt++;
         if (in_ready[dd] !== 1'b0)
            $display("FAIL reset_in_ready dut%0d got=%b exp=0", dd, in_ready[dd]);
         else pass_cnt++;
         total_cnt++;
         if (out_valid[dd] !== 1'b0)
            $display("FAIL reset_out_valid dut%0d got=%b exp=0", dd, out_valid[dd]);
         else pass_cnt++;
         total_cnt++;
         if (lanes_of(dd) !== 64'h0)
            $display("FAIL reset_lanes dut%0d got=%h exp=0", dd, lanes_of(dd));
         else pass_cnt++;
         total_cnt++;
         if (all_ones[dd] !== 1'b0)
            $display("FAIL reset_all_ones dut%0d got=%b exp=0", dd, all_ones[dd]);
         else pass_cnt++;
      end
      tick();
      for (int dd = 0; dd < ND; dd++) begin
         rst_n[dd]    = 1'b1;
         in_valid[dd] = 1'b0;
      end
      tick();
   endtask

   task automatic test_basic();
      exp_t e;
      out_ready[0] = 1'b0;
      send(0, 8'h12);
      @(negedge clk);
      total_cnt++;
      if (out_valid[0] !== 1'b0)
         $display("FAIL basic_early_valid got=%b exp=0", out_valid[0]);
      else pass_cnt++;
      tick();
      send(0, 8'h34);
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[0] !== 1'b1)
         $display("FAIL basic_valid got=%b exp=1", out_valid[0]);
      else pass_cnt++;
      total_cnt++;
      if (lanes_of(0) !== e.lanes)
         $display("FAIL basic_lanes got=%h exp=%h", lanes_of(0), e.lanes);
      else pass_cnt++;
      total_cnt++;
      if (all_ones[0] !== e.ones)
         $display("FAIL basic_all_ones got=%b exp=%b", all_ones[0], e.ones);
      else pass_cnt++;
      tick();
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h56;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         total_cnt++;
         if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1)
            $display("FAIL stall_hs cyc%0d in_ready=%b out_valid=%b exp=0/1",
                     s, in_ready[0], out_valid[0]);
         else pass_cnt++;
         total_cnt++;
         if (lanes_of(0) !== e.lanes)
            $display("FAIL stall_lanes cyc%0d got=%h exp=%h", s, lanes_of(0), e.lanes);
         else pass_cnt++;
         tick();
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (out_valid[0] !== 1'b0)
         $display("FAIL basic_release got=%b exp=0", out_valid[0]);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_all_ones();
      exp_t e;
      out_ready[1] = 1'b0;
      for (int i = 0; i < 8; i++) send(1, 8'hFF);
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[1] !== 1'b1 || lanes_of(1) !== e.lanes)
         $display("FAIL ones_group valid=%b lanes=%h exp=1 %h",
                  out_valid[1], lanes_of(1), e.lanes);
      else pass_cnt++;
      total_cnt++;
      if (all_ones[1] !== e.ones)
         $display("FAIL ones_flag got=%b exp=%b", all_ones[1], e.ones);
      else pass_cnt++;
      tick();
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
      for (int i = 0; i < 7; i++) send(1, 8'hFF);
      send(1, 8'hFE);
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[1] !== 1'b1 || lanes_of(1) !== e.lanes)
         $display("FAIL notones_group valid=%b lanes=%h exp=1 %h",
                  out_valid[1], lanes_of(1), e.lanes);
      else pass_cnt++;
      total_cnt++;
      if (all_ones[1] !== e.ones)
         $display("FAIL notones_flag got=%b exp=%b", all_ones[1], e.ones);
      else pass_cnt++;
      tick();
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   wi     = 1;
      int   groups = 0;
      out_ready[0] = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         if (wi <= 6) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'(wi);
         end else begin
            in_valid[0] = 1'b0;
         end
         @(negedge clk);
         if (in_valid[0]) begin
            total_cnt++;
            if (in_ready[0] !== 1'b1)
               $display("FAIL b2b_in_ready cyc%0d got=%b exp=1", cyc, in_ready[0]);
            else pass_cnt++;
            if (in_ready[0] === 1'b1) begin
               model_word(0, in_data[0]);
               wi++;
            end
         end
         if (out_valid[0] === 1'b1) begin
            groups++;
            total_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL b2b_extra_group lanes=%h exp=none", lanes_of(0));
            end else begin
               e = sb.pop_front();
               if (lanes_of(0) !== e.lanes)
                  $display("FAIL b2b_lanes cyc%0d got=%h exp=%h", cyc, lanes_of(0), e.lanes);
               else pass_cnt++;
            end
         end
         tick();
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      total_cnt++;
      if (groups != 3 || sb.size() != 0)
         $display("FAIL b2b_groups seen=%0d pending=%0d exp=3 0", groups, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_flush();
      exp_t e;
      out_ready[2] = 1'b0;
      send(2, 8'hA1);
      send(2, 8'hA2);
      flush[2]    = 1'b1;
      in_valid[2] = 1'b1;
      in_data[2]  = 8'hEE;
      @(negedge clk);
      total_cnt++;
      if (in_ready[2] !== 1'b1)
         $display("FAIL flush_in_ready got=%b exp=1", in_ready[2]);
      else pass_cnt++;
      tick();
      flush[2]    = 1'b0;
      in_valid[2] = 1'b0;
      model_reset(2);
      send(2, 8'hB0);
      send(2, 8'hB1);
      send(2, 8'hB2);
      @(negedge clk);
      total_cnt++;
      if (out_valid[2] !== 1'b0)
         $display("FAIL flush_early_valid got=%b exp=0", out_valid[2]);
      else pass_cnt++;
      tick();
      send(2, 8'hB3);
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[2] !== 1'b1 || lanes_of(2) !== e.lanes)
         $display("FAIL flush_group valid=%b lanes=%h exp=1 %h",
                  out_valid[2], lanes_of(2), e.lanes);
      else pass_cnt++;
      tick();
      flush[2] = 1'b1;
      tick();
      flush[2] = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (out_valid[2] !== 1'b0 || all_ones[2] !== 1'b0)
         $display("FAIL hold_flush valid=%b all_ones=%b exp=0 0",
                  out_valid[2], all_ones[2]);
      else pass_cnt++;
      total_cnt++;
      if (lanes_of(2) !== e.lanes)
         $display("FAIL hold_flush_lanes got=%h exp=%h", lanes_of(2), e.lanes);
      else pass_cnt++;
      tick();
      for (int i = 0; i < 4; i++) send(2, 8'hC0 + 8'(i));
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[2] !== 1'b1 || lanes_of(2) !== e.lanes)
         $display("FAIL post_flush_group valid=%b lanes=%h exp=1 %h",
                  out_valid[2], lanes_of(2), e.lanes);
      else pass_cnt++;
      tick();
      out_ready[2] = 1'b1;
      tick();
      out_ready[2] = 1'b0;
   endtask

   task automatic test_mid_reset();
      exp_t e;
      out_ready[3] = 1'b0;
      send(3, 8'h01);
      send(3, 8'h02);
      rst_n[3]    = 1'b0;
      in_valid[3] = 1'b1;
      in_data[3]  = 8'h33;
      @(negedge clk);
      total_cnt++;
      if (in_ready[3] !== 1'b0)
         $display("FAIL midrst_in_ready got=%b exp=0", in_ready[3]);
      else pass_cnt++;
      tick();
      rst_n[3]    = 1'b1;
      in_valid[3] = 1'b0;
      model_reset(3);
      @(negedge clk);
      total_cnt++;
      if (out_valid[3] !== 1'b0 || lanes_of(3) !== 64'h0)
         $display("FAIL midrst_clear valid=%b lanes=%h exp=0 0",
                  out_valid[3], lanes_of(3));
      else pass_cnt++;
      tick();
      send(3, 8'h07);
      send(3, 8'h08);
      send(3, 8'h09);
      @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (out_valid[3] !== 1'b1 || lanes_of(3) !== e.lanes)
         $display("FAIL midrst_group valid=%b lanes=%h exp=1 %h",
                  out_valid[3], lanes_of(3), e.lanes);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_back_to_back();
      test_flush();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lane_deserializer.md
Name: lane_deserializer

Overview:
- Stream-to-lanes deserializer: the inverse of the 8-operand reduction blocks. It accepts one WIDTH-bit word per valid/ready handshake and distributes consecutive words into output lanes a..h.
- Once PORT_NUM lanes are filled, it presents them as one group with an output valid/ready handshake.
- It also flags whether every filled lane is all-ones, which is the same value a downstream 8-input reduction-AND block would compute.
- It sits between a serial producer and the multi-operand combinational blocks.

Parameters:
- PORT_NUM, 2, number of lanes filled per group; legal range 1..8. Elaborate with a fatal error outside this range.
- WIDTH, 8, bit width of each word and each lane.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- flush  input  1  synchronous drop of any partial or held group
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word to deposit in the next lane
- out_valid  output  1  lanes a..h hold a complete group
- out_ready  input  1  consumer takes the group this cycle
- a,b,c,d,e,f,g,h  output  WIDTH each  lane registers, filled in order a first
- all_ones  output  1  out_valid AND every used lane equals all-ones

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=FILL, idx=0.
  - a..h=0, out_valid=0, all_ones=0.
  - in_ready is forced 0 while rst_n is low.
- States:
  - FILL: collecting words; idx counts 0..PORT_NUM-1, 3 bits.
  - HOLD: group complete, waiting for the consumer.
- in_ready = rst_n AND (state==FILL OR (state==HOLD AND out_ready)). It is combinational and must not depend on in_valid.
- Accept = in_valid AND in_ready.
- FILL, on accept:
  - lane[idx] <= in_data.
  - If idx==PORT_NUM-1: go to HOLD, set out_valid=1 the next cycle, and set idx=0.
  - Otherwise idx <= idx+1.
- Latency: out_valid rises on the cycle after the PORT_NUM-th accepted word.
- HOLD:
  - out_valid=1; lanes are stable and must not change while out_valid=1 and out_ready=0.
  - On out_ready without accept: go to FILL, out_valid=0.
  - On out_ready with accept (same-cycle pass-through):
    - lane a <= in_data; the other lanes keep their old values until overwritten.
    - If PORT_NUM==1: stay in HOLD with out_valid=1 (new group).
    - Otherwise: go to FILL with idx=1, out_valid=0.
  - This gives full throughput of one word per cycle.
- Lanes with index >= PORT_NUM are tied to 0 and are never written.
- all_ones is registered alongside out_valid: it is the AND of all bits of lanes 0..PORT_NUM-1 for the group being presented, and 0 whenever out_valid=0.
- flush (priority below reset, above everything else):
  - Next state FILL, idx=0, out_valid=0, all_ones=0.
  - Lane contents are unchanged.
  - in_ready is still as defined, but any word accepted in the flush cycle is discarded and idx is not advanced.
- in_valid while in HOLD with out_ready=0: in_ready=0, nothing happens, and the producer must hold its word.
- Reset asserted mid-group: the partial group is discarded and all outputs return to reset values on that edge.
- No X-propagation: every register has a defined reset value.

Decomposition:
- Shared package lane_pkg holds:
  - constant MAX_PORTS=8;
  - the state enum typedef {FILL, HOLD};
  - the idx width constant $clog2(MAX_PORTS)=3.
- No sub-module is needed. The lane register file plus the FSM fit in one module. The all_ones reduction is an inline generate loop over the used lanes.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, a..h=0, all_ones=0.
- Basic group (PORT_NUM=2, WIDTH=8): accept 0x12 then 0x34, out_ready=0 -> next cycle out_valid=1, a=0x12, b=0x34, c..h=0, all_ones=0. Lanes stay stable for 3 stall cycles with in_ready=0.
- All-ones group (PORT_NUM=8): accept eight words of 0xFF -> out_valid=1, all_ones=1. Repeat with h=0xFE -> all_ones=0.
- Back-to-back (PORT_NUM=2): in_valid=1 every cycle, out_ready=1 every cycle, data 1,2,3,4,5,6 -> groups (1,2), (3,4), (5,6) are each presented one cycle. No word is lost; in_ready stays 1 throughout.
- Flush (PORT_NUM=4): accept 0xA1 and 0xA2, then assert flush for 1 cycle, then accept 4 words 0xB0..0xB3 -> out_valid=1 only after the 4th B word, with a..d=0xB0..0xB3. Flush during HOLD drops out_valid on the next cycle.
- Mid-group reset (PORT_NUM=3): accept 2 words, pulse rst_n=0 for 1 cycle, then accept 3 words 7,8,9 -> out_valid=1 with a=7, b=8, c=9.
